// File: rtl/io_vip_seq.sv
// io_vip_seq: per-bit-direction pad driver that plays back queued (value, hold) pairs,
// plus a pad monitor that records every sample or only value changes into a capture queue.
module io_vip_seq #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int HOLD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  oe,
  input  logic [WIDTH-1:0]  io_i,
  output logic [WIDTH-1:0]  io_o,
  output logic [WIDTH-1:0]  io_t,
  input  logic              drv_valid,
  output logic              drv_ready,
  input  logic [WIDTH-1:0]  drv_data,
  input  logic [HOLD_W-1:0] drv_hold,
  output logic              busy,
  input  logic              cap_en,
  input  logic              cap_on_change,
  input  logic              cap_clr,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [WIDTH-1:0]  cap_data,
  output logic              cap_overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_nstate;
  logic [WIDTH-1:0]  r_dmem [DEPTH];
  logic [HOLD_W-1:0] r_hmem [DEPTH];
  logic [WIDTH-1:0]  r_cmem [DEPTH];
  logic [AW:0]       r_dwp, r_drp, r_cwp, r_crp;
  logic [HOLD_W-1:0] r_cnt, w_ncnt;
  logic [WIDTH-1:0]  r_io_o, w_nio, r_io_t, r_prev, w_s;
  logic              r_rdy, r_en_d, r_ovf;
  logic              w_dfull, w_dempty, w_dpush, w_dpop;
  logic              w_cfull, w_cempty, w_cpush, w_cpop, w_ev, w_first;

  assign w_dfull   = (r_dwp ^ r_drp) == {1'b1, {AW{1'b0}}};
  assign w_dempty  = r_dwp == r_drp;
  assign drv_ready = r_rdy & !w_dfull;
  assign w_dpush   = drv_valid & drv_ready;
  assign busy      = (r_state == HOLD) | !w_dempty;
  assign io_o      = r_io_o;
  assign io_t      = r_io_t;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nio    = r_io_o;
    w_dpop   = 1'b0;
    if (r_state == IDLE || r_cnt == '0) begin
      if (!w_dempty) begin
        w_dpop   = 1'b1;
        w_nio    = r_dmem[r_drp[AW-1:0]];
        w_ncnt   = r_hmem[r_drp[AW-1:0]];
        w_nstate = HOLD;
      end else begin
        w_nstate = IDLE;
      end
    end else begin
      w_ncnt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_io_o  <= '0;
      r_io_t  <= '1;
      r_dwp   <= '0;
      r_drp   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_io_o  <= w_nio;
      r_io_t  <= ~oe;
      r_rdy   <= 1'b1;
      if (w_dpush) r_dwp <= r_dwp + 1'b1;
      if (w_dpop) r_drp <= r_drp + 1'b1;
    end

  always_ff @(posedge clk)
    if (w_dpush) begin
      r_dmem[r_dwp[AW-1:0]] <= drv_data;
      r_hmem[r_dwp[AW-1:0]] <= drv_hold;
    end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = io_i;
  end else begin : g_sync
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        r_sync <= '{default: '0};
      end else begin
        r_sync[0] <= io_i;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    assign w_s = r_sync[SYNC_STAGES-1];
  end

  assign w_cfull      = (r_cwp ^ r_crp) == {1'b1, {AW{1'b0}}};
  assign w_cempty     = r_cwp == r_crp;
  assign cap_valid    = !w_cempty;
  assign cap_data     = r_cmem[r_crp[AW-1:0]];
  assign cap_overflow = r_ovf;
  assign w_first      = cap_en & !r_en_d;
  assign w_ev         = cap_en & (!cap_on_change | (w_s != r_prev) | w_first);
  assign w_cpop       = cap_valid & cap_ready;
  assign w_cpush      = w_ev & !cap_clr & (!w_cfull | w_cpop);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_cwp  <= '0;
      r_crp  <= '0;
      r_ovf  <= 1'b0;
      r_prev <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_prev <= w_s;
      r_en_d <= cap_en;
      if (cap_clr) begin
        r_cwp <= '0;
        r_crp <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_cpush) r_cwp <= r_cwp + 1'b1;
        if (w_cpop) r_crp <= r_crp + 1'b1;
        if (w_ev && w_cfull && !w_cpop) r_ovf <= 1'b1;
      end
    end

  always_ff @(posedge clk)
    if (w_cpush) r_cmem[r_cwp[AW-1:0]] <= w_s;
endmodule

// File: tb/tb_io_vip_seq.sv
// tb_io_vip_seq: directed tables and sequences for io_vip_seq plus a random run
// compared against a queue-based reference model of the player and capture path.
module tb_io_vip_seq;
  localparam int W = 8;
  localparam int D = 16;
  localparam int SS = 2;
  logic clk = 1'b0, resetn = 1'b0;
  logic [W-1:0] oe, io_i, io_o, io_t, drv_data, cap_data;
  logic [7:0] drv_hold;
  logic drv_valid, drv_ready, busy, cap_en, cap_on_change, cap_clr, cap_valid, cap_ready, cap_overflow;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  io_vip_seq dut (
    .clk(clk), .resetn(resetn), .oe(oe), .io_i(io_i), .io_o(io_o), .io_t(io_t),
    .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_data(drv_data), .drv_hold(drv_hold),
    .busy(busy), .cap_en(cap_en), .cap_on_change(cap_on_change), .cap_clr(cap_clr),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data), .cap_overflow(cap_overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [7:0] d; int h;} ent_t;
  ent_t m_dq[$];
  logic [W-1:0] m_cq[$], m_pipe[$], m_io, m_iot, m_prev, m_s;
  int m_left, m_n;
  bit m_started, m_ovf, m_enp, m_push, m_pop, m_ev;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_dq.delete(); m_cq.delete(); m_pipe.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      m_io = '0; m_iot = '1; m_left = 0; m_started = 0; m_ovf = 0; m_prev = '0; m_enp = 0;
    end else begin
      m_push = drv_valid && m_started && m_dq.size() < D;
      if (m_left > 1) m_left--;
      else if (m_dq.size() > 0) begin
        m_io = m_dq[0].d; m_left = m_dq[0].h + 1; void'(m_dq.pop_front());
      end else m_left = 0;
      if (m_push) m_dq.push_back('{drv_data, int'(drv_hold)});
      m_started = 1;
      m_iot = ~oe;
      m_s = m_pipe[0];
      m_ev = cap_en && (!cap_on_change || m_s != m_prev || !m_enp);
      m_pop = m_cq.size() > 0 && cap_ready;
      m_n = m_cq.size();
      if (cap_clr) begin
        m_cq.delete(); m_ovf = 0;
      end else begin
        if (m_pop) void'(m_cq.pop_front());
        if (m_ev) begin
          if (m_n < D || m_pop) m_cq.push_back(m_s);
          else m_ovf = 1;
        end
      end
      m_prev = m_s; m_enp = cap_en;
      m_pipe.push_back(io_i); void'(m_pipe.pop_front());
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("rnd_io_o", io_o, m_io);
    chk("rnd_io_t", io_t, m_iot);
    chk("rnd_busy", busy, m_left > 0 || m_dq.size() > 0);
    chk("rnd_drv_ready", drv_ready, m_started && m_dq.size() < D);
    chk("rnd_cap_valid", cap_valid, m_cq.size() > 0);
    if (m_cq.size() > 0) chk("rnd_cap_data", cap_data, m_cq[0]);
    chk("rnd_overflow", cap_overflow, m_ovf);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {logic [7:0] d; logic [7:0] h;} pb_t;
  typedef struct {logic [7:0] oe; logic [7:0] iot;} dir_t;
  pb_t pb[2];
  dir_t dir[6];
  logic [7:0] exp_q[$], seen[$], rv[$], got[$];
  logic [7:0] io4[6];
  int rl[$];
  int acc, guard, waited;

  initial begin
    pb[0] = '{8'hA5, 8'd2}; pb[1] = '{8'h3C, 8'd0};
    dir[0] = '{8'h00, 8'hFF}; dir[1] = '{8'hFF, 8'h00}; dir[2] = '{8'h5A, 8'hA5};
    dir[3] = '{8'hC3, 8'h3C}; dir[4] = '{8'h0F, 8'hF0}; dir[5] = '{8'hF0, 8'h0F};
    io4 = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h22};
    oe = '0; io_i = '0; drv_valid = 0; drv_data = '0; drv_hold = '0;
    cap_en = 0; cap_on_change = 0; cap_clr = 0; cap_ready = 0;

    repeat (3) @(negedge clk);
    chk("rst_io_t", io_t, 8'hFF);
    chk("rst_io_o", io_o, 8'h00);
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drv_ready", drv_ready, 0);
    chk("rst_overflow", cap_overflow, 0);
    resetn = 1;
    @(negedge clk);
    chk("rel_drv_ready", drv_ready, 1);

    oe = 8'hFF;
    foreach (pb[i]) begin
      drv_valid = 1; drv_data = pb[i].d; drv_hold = pb[i].h;
      for (int k = 0; k <= int'(pb[i].h); k++) exp_q.push_back(pb[i].d);
      @(negedge clk);
    end
    drv_valid = 0;
    chk("pb_io_t", io_t, 8'h00);
    foreach (exp_q[k]) begin
      chk("pb_io_o", io_o, exp_q[k]);
      chk("pb_busy", busy, 1);
      @(negedge clk);
    end
    chk("pb_busy_end", busy, 0);
    chk("pb_io_o_keep", io_o, 8'h3C);

    foreach (dir[i]) begin
      oe = dir[i].oe;
      @(negedge clk);
      chk("dir_io_t", io_t, dir[i].iot);
      chk("dir_io_o", io_o, 8'h3C);
    end
    oe = 8'hFF;

    acc = 0; guard = 0; drv_hold = 8'd10;
    while (guard < 100 && drv_ready) begin
      drv_data = 8'h40 + 8'(acc); drv_valid = 1;
      @(negedge clk);
      acc++; guard++; seen.push_back(io_o);
    end
    chk("full_accepted", acc, 18);
    chk("full_ready", drv_ready, 0);
    drv_data = 8'hEE; waited = 0;
    while (!drv_ready && waited < 40) begin
      @(negedge clk);
      waited++; seen.push_back(io_o);
    end
    drv_valid = 0;
    chk("full_refuse_wait", waited, 6);
    guard = 0;
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++; seen.push_back(io_o);
    end
    chk("full_drained", busy, 0);
    foreach (seen[k])
      if (k == 0 || seen[k] != seen[k-1]) begin rv.push_back(seen[k]); rl.push_back(1); end
      else rl[rl.size()-1] += 1;
    chk("full_runs", rv.size(), 19);
    for (int i = 0; i < 18; i++) if (i + 1 < rv.size()) begin
      chk("full_order", rv[i+1], 8'h40 + 8'(i));
      if (i < 17) chk("full_hold_len", rl[i+1], 11);
    end

    io_i = '0; cap_clr = 1;
    @(negedge clk);
    cap_clr = 0; cap_on_change = 1;
    repeat (3) @(negedge clk);
    cap_en = 1;
    foreach (io4[i]) begin io_i = io4[i]; @(negedge clk); end
    repeat (4) @(negedge clk);
    cap_en = 0; cap_ready = 1; guard = 0;
    while (cap_valid && guard < 10) begin got.push_back(cap_data); @(negedge clk); guard++; end
    cap_ready = 0;
    chk("chg_count", got.size(), 3);
    for (int i = 0; i < 3; i++) if (i < got.size()) chk("chg_data", got[i], 8'h11 * 8'(i));

    cap_on_change = 0; cap_en = 1;
    for (int i = 0; i < 20; i++) begin io_i = 8'(i); @(negedge clk); end
    chk("ovf_set", cap_overflow, 1);
    chk("ovf_valid", cap_valid, 1);
    cap_clr = 1;
    @(negedge clk);
    cap_clr = 0; cap_en = 0;
    chk("clr_valid", cap_valid, 0);
    chk("clr_overflow", cap_overflow, 0);
    cap_en = 1;
    for (int i = 0; i < 20; i++) begin io_i = 8'h80 + 8'(i); @(negedge clk); end
    cap_en = 0; cap_ready = 1; got.delete(); guard = 0;
    while (cap_valid && guard < 40) begin got.push_back(cap_data); @(negedge clk); guard++; end
    cap_ready = 0;
    chk("ovf_held", got.size(), 16);
    chk("ovf_sticky", cap_overflow, 1);
    for (int i = 0; i < 16; i++) if (i < got.size()) chk("ovf_data", got[i], i < 2 ? 8'h13 : 8'h80 + 8'(i - 2));

    drv_hold = 8'd20; drv_data = 8'h77; drv_valid = 1;
    @(negedge clk);
    drv_data = 8'h88; drv_hold = 8'd0;
    @(negedge clk);
    drv_valid = 0;
    repeat (3) @(negedge clk);
    chk("ar_pre_io_o", io_o, 8'h77);
    chk("ar_pre_io_t", io_t, 8'h00);
    #2 resetn = 0;
    #1;
    chk("ar_io_t", io_t, 8'hFF);
    chk("ar_io_o", io_o, 8'h00);
    chk("ar_busy", busy, 0);
    chk("ar_ovf", cap_overflow, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("ar_drv_ready", drv_ready, 1);
    for (int i = 0; i < 30; i++) begin
      chk("ar_no_replay", io_o, 8'h00);
      chk("ar_idle", busy, 0);
      @(negedge clk);
    end

    resetn = 0;
    @(negedge clk);
    resetn = 1; chk_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drv_valid = 1'($urandom_range(0, 1));
      drv_data = 8'($urandom);
      drv_hold = 8'($urandom_range(0, 3));
      oe = 8'($urandom);
      io_i = 8'h11 * 8'($urandom_range(0, 3));
      cap_en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) cap_on_change = ~cap_on_change;
      cap_ready = ((i / 150) % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cap_clr = $urandom_range(0, 59) == 0;
    end
    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
